// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the rPLL sequencer.
package pll_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    RST_HOLD  = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    SETTLE    = 3'd4,
    FAIL      = 3'd5
  } state_e;

  // Power-on values for the dynamic phase/duty inputs of the rPLL
  localparam logic [3:0] PSDA_INIT_DEF = 4'b0000;
  localparam logic [3:0] DUTY_INIT_DEF = 4'b1000;

  // Width of a shared counter that must reach (largest count - 1)
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_seq_ctrl_sync_2ff.sv
// Two-flop synchronizer for slow level signals (PLL LOCK, LP lines).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives a clean level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_seq_ctrl.sv
// rPLL sequencer: reset pulse, lock qualification with retries, dynamic
// phase/duty updates, and a clean ready / capture-domain reset.
module pll_seq_ctrl
  import pll_seq_pkg::*;
#(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 50000,
  parameter int         STABLE_CYCLES = 1024,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         MAX_RETRY     = 8,
  parameter logic [3:0] PSDA_INIT     = PSDA_INIT_DEF,
  parameter logic [3:0] DUTY_INIT     = DUTY_INIT_DEF
) (
  input  logic                           clkin,
  input  logic                           reset,
  input  logic                           pll_lock,
  output logic                           pll_reset,
  output logic [3:0]                     psda,
  output logic [3:0]                     dutyda,
  input  logic                           ph_req,
  input  logic [3:0]                     ph_val,
  input  logic [3:0]                     duty_val,
  output logic                           ph_ack,
  output logic                           ready,
  output logic                           sys_reset,
  output logic                           fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic                           lock_lost,
  input  logic                           clr_sticky
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, SETTLE_CYCLES);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  // Terminal counter values for each timed state
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
  logic [3:0]       psda_q, psda_d;
  logic [3:0]       dutyda_q, dutyda_d;
  logic             ph_ack_q, ph_ack_d;
  logic             ready_q, ready_d;
  logic             sys_reset_q, sys_reset_d;
  logic             fail_q, fail_d;
  logic             pll_reset_q, pll_reset_d;
  logic             lock_lost_q, lock_lost_d;
  logic             lock_s;
  logic             lost_set;
  logic             accept;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clkin),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next state, counters, and the values the output flops will load
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    lost_set  = 1'b0;
    accept    = 1'b0;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    retry_inc = (retry_q == RTY_MAX) ? retry_q : retry_q + 1'b1;

    case (state_q)
      RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc == RTY_MAX) ? FAIL : RST_HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STABLE: begin
        // A dropout here is a lock that never settled, not a failed attempt
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == ST_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RUN: begin
        // Lock loss has priority over a pending phase request
        if (!lock_s) begin
          state_d  = RST_HOLD;
          cnt_d    = '0;
          lost_set = 1'b1;
        end else if (ph_req) begin
          state_d = SETTLE;
          cnt_d   = '0;
          accept  = 1'b1;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_d  = RST_HOLD;
          cnt_d    = '0;
          lost_set = 1'b1;
        end else if (cnt_q == SE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = '0;
      end
    endcase

    // Phase/duty persist across relocks; only an accepted request changes them
    psda_d      = accept ? ph_val : psda_q;
    dutyda_d    = accept ? duty_val : dutyda_q;
    ph_ack_d    = accept;
    // A new loss event beats a simultaneous clear
    lock_lost_d = lost_set | (lock_lost_q & ~clr_sticky);
    pll_reset_d = (state_d == RST_HOLD) || (state_d == FAIL);
    ready_d     = (state_d == RUN);
    sys_reset_d = ~ready_d;
    fail_d      = (state_d == FAIL);
  end

  // State, counters and all registered outputs
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= RST_HOLD;
      cnt_q       <= '0;
      retry_q     <= '0;
      psda_q      <= PSDA_INIT;
      dutyda_q    <= DUTY_INIT;
      ph_ack_q    <= 1'b0;
      ready_q     <= 1'b0;
      sys_reset_q <= 1'b1;
      fail_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      psda_q      <= psda_d;
      dutyda_q    <= dutyda_d;
      ph_ack_q    <= ph_ack_d;
      ready_q     <= ready_d;
      sys_reset_q <= sys_reset_d;
      fail_q      <= fail_d;
      pll_reset_q <= pll_reset_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign psda      = psda_q;
  assign dutyda    = dutyda_q;
  assign ph_ack    = ph_ack_q;
  assign ready     = ready_q;
  assign sys_reset = sys_reset_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl: phase/deadline model checked every cycle, plus
// hand-computed checkpoints at the cycle numbers derived from the rules.
module tb_pll_seq_ctrl;

  localparam int P_RST = 4;
  localparam int P_TO  = 100;
  localparam int P_ST  = 16;
  localparam int P_SE  = 8;
  localparam int P_MR  = 3;
  localparam int RW    = $clog2(P_MR + 1);

  // Model phases
  localparam int M_HOLD = 0;
  localparam int M_WAIT = 1;
  localparam int M_STBL = 2;
  localparam int M_RUN  = 3;
  localparam int M_SETL = 4;
  localparam int M_DEAD = 5;

  logic          clkin = 1'b0;
  logic          reset;
  logic          pll_lock;
  logic          pll_reset;
  logic [3:0]    psda;
  logic [3:0]    dutyda;
  logic          ph_req;
  logic [3:0]    ph_val;
  logic [3:0]    duty_val;
  logic          ph_ack;
  logic          ready;
  logic          sys_reset;
  logic          fail;
  logic [RW-1:0] retry_cnt;
  logic          lock_lost;
  logic          clr_sticky;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state
  int m_ph    = M_HOLD;
  int m_k     = 0;
  int m_t0    = 0;
  int m_retry = 0;
  int m_lost  = 0;
  int m_psda  = 0;
  int m_duty  = 8;
  int m_ack   = 0;
  bit hist[$];

  pll_seq_ctrl #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_ST),
    .SETTLE_CYCLES (P_SE),
    .MAX_RETRY     (P_MR)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .psda       (psda),
    .dutyda     (dutyda),
    .ph_req     (ph_req),
    .ph_val     (ph_val),
    .duty_val   (duty_val),
    .ph_ack     (ph_ack),
    .ready      (ready),
    .sys_reset  (sys_reset),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost),
    .clr_sticky (clr_sticky)
  );

  always #5 clkin = ~clkin;

  // edges since reset release
  always @(posedge clkin or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic m_enter(input int ph);
    m_ph = ph;
    m_t0 = m_k;
  endtask

  task automatic model_reset();
    m_ph = M_HOLD; m_k = 0; m_t0 = 0; m_retry = 0; m_lost = 0;
    m_psda = 0; m_duty = 8; m_ack = 0;
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
  endtask

  // One clock edge of the model: the sequencer reacts to the LOCK level that
  // was sampled two edges earlier; phase durations come from entry timestamps.
  task automatic model_step();
    bit ls;
    int el;
    bit set_now;
    m_k++;
    hist.push_front(pll_lock);
    ls = hist[2];
    hist = hist[0:2];
    el = m_k - m_t0;
    m_ack = 0;
    set_now = 0;
    case (m_ph)
      M_HOLD: if (el == P_RST) m_enter(M_WAIT);
      M_WAIT: begin
        if (ls) m_enter(M_STBL);
        else if (el == P_TO) begin
          m_retry = (m_retry < P_MR) ? m_retry + 1 : P_MR;
          m_enter((m_retry == P_MR) ? M_DEAD : M_HOLD);
        end
      end
      M_STBL: begin
        if (!ls) m_enter(M_WAIT);
        else if (el == P_ST) m_enter(M_RUN);
      end
      M_RUN: begin
        if (!ls) begin set_now = 1; m_enter(M_HOLD); end
        else if (ph_req) begin
          m_psda = ph_val; m_duty = duty_val; m_ack = 1;
          m_enter(M_SETL);
        end
      end
      M_SETL: begin
        if (!ls) begin set_now = 1; m_enter(M_HOLD); end
        else if (el == P_SE) m_enter(M_RUN);
      end
      default: ;
    endcase
    if (set_now) m_lost = 1;
    else if (clr_sticky) m_lost = 0;
  endtask

  always @(posedge clkin or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  // Compare every output against the model each cycle
  always @(negedge clkin) begin
    check("pll_reset", int'(pll_reset), int'(m_ph == M_HOLD || m_ph == M_DEAD));
    check("ready",     int'(ready),     int'(m_ph == M_RUN));
    check("sys_reset", int'(sys_reset), int'(m_ph != M_RUN));
    check("fail",      int'(fail),      int'(m_ph == M_DEAD));
    check("retry_cnt", int'(retry_cnt), m_retry);
    check("lock_lost", int'(lock_lost), m_lost);
    check("psda",      int'(psda),      m_psda);
    check("dutyda",    int'(dutyda),    m_duty);
    check("ph_ack",    int'(ph_ack),    m_ack);
  end

  // Advance to the falling edge that follows edge n
  task automatic wait_until(input int n);
    do @(negedge clkin); while (cyc < n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc %0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pll_lock = 1'b0; ph_req = 1'b0; ph_val = 4'h0;
    duty_val = 4'h0; clr_sticky = 1'b0;
    repeat (3) @(negedge clkin);
    check("lit_rst_psda", int'(psda), 0);
    check("lit_rst_duty", int'(dutyda), 8);
    reset = 1'b0;

    // Lock 10 cycles after pll_reset falls (falls at edge 4)
    wait_until(3);  check("lit_prst_hi", int'(pll_reset), 1);
    wait_until(4);  check("lit_prst_lo", int'(pll_reset), 0);
    wait_until(14); pll_lock = 1'b1;
    wait_until(32); check("lit_ready_early", int'(ready), 0);
    wait_until(33); check("lit_ready_up", int'(ready), 1);
    check("lit_sysrst_lo", int'(sys_reset), 0);
    check("lit_retry0", int'(retry_cnt), 0);

    // Phase request, then a second request during settle
    wait_until(40); ph_req = 1'b1; ph_val = 4'h5; duty_val = 4'h6;
    wait_until(41);
    check("lit_ack", int'(ph_ack), 1);
    check("lit_psda5", int'(psda), 5);
    check("lit_duty6", int'(dutyda), 6);
    check("lit_settle_rdy", int'(ready), 0);
    ph_req = 1'b0;
    wait_until(42); check("lit_ack_once", int'(ph_ack), 0);
    wait_until(44); ph_req = 1'b1; ph_val = 4'h9; duty_val = 4'h3;
    wait_until(46); ph_req = 1'b0; check("lit_psda_keep", int'(psda), 5);
    wait_until(48); check("lit_settle_end", int'(ready), 0);
    wait_until(49); check("lit_run_again", int'(ready), 1);

    // Lock loss in RUN: first sampled at edge 56, acted on at edge 58
    wait_until(55); pll_lock = 1'b0;
    wait_until(57); check("lit_loss_prst0", int'(pll_reset), 0);
    wait_until(58);
    check("lit_loss_prst1", int'(pll_reset), 1);
    check("lit_lost_set", int'(lock_lost), 1);
    wait_until(60); pll_lock = 1'b1;
    wait_until(79);
    check("lit_relock_rdy", int'(ready), 1);
    check("lit_relock_psda", int'(psda), 5);
    check("lit_relock_retry", int'(retry_cnt), 0);
    wait_until(82); clr_sticky = 1'b1;
    wait_until(83); clr_sticky = 1'b0;
    check("lit_lost_clr", int'(lock_lost), 0);

    // Lock loss, phase request and clear all on edge 93
    wait_until(90); pll_lock = 1'b0;
    wait_until(92); ph_req = 1'b1; ph_val = 4'h7; duty_val = 4'h7; clr_sticky = 1'b1;
    wait_until(93); ph_req = 1'b0; clr_sticky = 1'b0;
    check("lit_race_ack", int'(ph_ack), 0);
    check("lit_race_psda", int'(psda), 5);
    check("lit_race_lost", int'(lock_lost), 1);

    // One-cycle glitch at STABLE count 10 (seen at edge 109)
    wait_until(95);  pll_lock = 1'b1;
    wait_until(106); pll_lock = 1'b0;
    wait_until(107); pll_lock = 1'b1;
    wait_until(114); check("lit_glitch_norun", int'(ready), 0);
    wait_until(125); check("lit_glitch_early", int'(ready), 0);
    wait_until(126); check("lit_glitch_rdy", int'(ready), 1);
    check("lit_glitch_retry", int'(retry_cnt), 0);

    // Asynchronous reset in the middle of SETTLE
    wait_until(130); ph_req = 1'b1; ph_val = 4'hA; duty_val = 4'hB;
    wait_until(131); ph_req = 1'b0; check("lit_psdaA", int'(psda), 10);
    wait_until(134);
    #2 reset = 1'b1;
    #1;
    check("lit_ar_prst", int'(pll_reset), 1);
    check("lit_ar_psda", int'(psda), 0);
    check("lit_ar_duty", int'(dutyda), 8);
    check("lit_ar_ack", int'(ph_ack), 0);
    check("lit_ar_ready", int'(ready), 0);
    check("lit_ar_sysrst", int'(sys_reset), 1);
    check("lit_ar_fail", int'(fail), 0);
    check("lit_ar_retry", int'(retry_cnt), 0);
    check("lit_ar_lost", int'(lock_lost), 0);
    pll_lock = 1'b0;
    repeat (2) @(negedge clkin);
    reset = 1'b0;

    // No lock at all: three 4+100 attempts, then FAIL
    wait_until(103); check("lit_to_r0", int'(retry_cnt), 0);
    wait_until(104); check("lit_to_r1", int'(retry_cnt), 1);
    check("lit_to_prst", int'(pll_reset), 1);
    wait_until(208); check("lit_to_r2", int'(retry_cnt), 2);
    wait_until(311); check("lit_to_nofail", int'(fail), 0);
    wait_until(312);
    check("lit_fail", int'(fail), 1);
    check("lit_fail_r3", int'(retry_cnt), 3);
    check("lit_fail_prst", int'(pll_reset), 1);
    wait_until(315); pll_lock = 1'b1; ph_req = 1'b1; ph_val = 4'hF; duty_val = 4'hF;
    wait_until(340);
    check("lit_fail_hold", int'(fail), 1);
    check("lit_fail_rdy", int'(ready), 0);
    check("lit_fail_ack", int'(ph_ack), 0);
    ph_req = 1'b0;

    @(negedge clkin);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_seq_ctrl.md
Name: pll_seq_ctrl

Overview:
Sequencer for the Gowin rPLL that feeds the D-PHY capture clock. It drives the PLL reset, qualifies LOCK, retries failed locks, and owns the dynamic phase and duty inputs (PSDA/DUTYDA). It hands the capture logic a clean "ready" and a reset that releases only after lock is stable. It runs on the free-running board clock that also feeds the PLL CLKIN.

Parameters:
RST_CYCLES, 16, cycles pll_reset is held high per attempt (>=2)
LOCK_TIMEOUT, 50000, cycles to wait for lock before a retry (1 ms at 50 MHz)
STABLE_CYCLES, 1024, consecutive synced-lock-high cycles required before ready
SETTLE_CYCLES, 64, cycles ready is held low after a phase/duty change
MAX_RETRY, 8, failed attempts before entering FAIL
PSDA_INIT, 4'b0000, psda value after reset
DUTY_INIT, 4'b1000, dutyda value after reset

Ports:
clkin  in  1  board clock, also the PLL reference
reset  in  1  asynchronous, active-high
pll_lock  in  1  rPLL LOCK, asynchronous to clkin
pll_reset  out  1  to rPLL RESET
psda  out  4  to rPLL PSDA
dutyda  out  4  to rPLL DUTYDA
ph_req  in  1  phase/duty change request, level
ph_val  in  4  requested psda
duty_val  in  4  requested dutyda
ph_ack  out  1  one-cycle pulse when the request is accepted
ready  out  1  PLL locked, stable and settled
sys_reset  out  1  active-high reset for the capture domain; equals ~ready, registered
fail  out  1  MAX_RETRY exhausted
retry_cnt  out  $clog2(MAX_RETRY+1)  failed attempts since reset
lock_lost  out  1  sticky: lock dropped while in RUN or SETTLE
clr_sticky  in  1  clears lock_lost

Behaviour:
- Interface: one clock, clkin. reset is asynchronous and active-high. All flops clear on reset.
- pll_lock passes through a 2-flop synchronizer (lock_s) before any use. This adds 2 cycles of latency.
- Reset values:
  - pll_reset=1, psda=PSDA_INIT, dutyda=DUTY_INIT
  - ph_ack=0, ready=0, sys_reset=1, fail=0, retry_cnt=0, lock_lost=0
  - state=RST_HOLD, counter=0
- States:
  - RST_HOLD: pll_reset=1. Count RST_CYCLES, then go to WAIT_LOCK with the counter cleared.
  - WAIT_LOCK: pll_reset=0.
    - lock_s=1 -> STABLE, counter cleared.
    - Counter reaches LOCK_TIMEOUT-1 -> increment retry_cnt. If the new count equals MAX_RETRY, go to FAIL; otherwise go to RST_HOLD.
  - STABLE: count consecutive lock_s=1 cycles.
    - lock_s=0 -> back to WAIT_LOCK, counter cleared. This does not count as a retry.
    - After STABLE_CYCLES -> RUN.
  - RUN: ready=1.
    - lock_s=0 -> RST_HOLD and set lock_lost. retry_cnt is not incremented.
    - ph_req=1 -> latch ph_val/duty_val into psda/dutyda the same cycle, pulse ph_ack, go to SETTLE.
  - SETTLE: ready=0, counter runs SETTLE_CYCLES, then RUN.
    - lock_s=0 -> RST_HOLD and set lock_lost.
    - ph_req is ignored; no ack is given.
  - FAIL: pll_reset=1, ready=0, fail=1. Terminal until reset.
- ready and sys_reset are registered. ready rises exactly 1 cycle after STABLE completes.
- Handshake: ph_ack fires only from RUN, at most once per request. The requester must drop ph_req after ph_ack; a held ph_req re-triggers on the first RUN cycle after SETTLE.
- psda and dutyda are not reset to their INIT values on a relock. The last accepted values persist.
- Simultaneous events:
  - lock loss and ph_req in the same RUN cycle: lock loss wins, no ack, psda unchanged.
  - clr_sticky and a new lock-loss event in the same cycle: set wins.
- Counters are sized $clog2 of the largest count parameter and saturate; they never wrap.
- retry_cnt saturates at MAX_RETRY.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum: RST_HOLD, WAIT_LOCK, STABLE, RUN, SETTLE, FAIL
  - counter-width function
  - default PSDA/DUTY constants
- One sub-module: sync_2ff, the lock synchronizer, reusable elsewhere for LOCK and for the LP-line inputs.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, SETTLE_CYCLES=8, MAX_RETRY=3.
- Lock rises 10 cycles after pll_reset falls -> pll_reset high for exactly 4 cycles; ready=1 and sys_reset=0 at 10+2+16+1 cycles after pll_reset falls; retry_cnt=0.
- pll_lock held at 0 -> three attempts of 4+100 cycles each; retry_cnt steps 1,2,3; fail=1, pll_reset=1 and ready=0 permanently after the third timeout.
- Lock glitches low for 1 cycle at STABLE count 10 -> returns to WAIT_LOCK, then needs a full 16 fresh cycles; retry_cnt unchanged.
- In RUN, ph_req=1 with ph_val=4'h5 and duty_val=4'h6 -> ph_ack pulse one cycle later, psda=5, dutyda=6, ready low for 8 cycles then high. A second ph_req during SETTLE gets no ack.
- In RUN, drop pll_lock -> lock_lost=1, pll_reset high 2 cycles later. After relock, psda still equals 5. clr_sticky clears lock_lost.
- Assert reset mid-SETTLE -> all outputs return to reset values immediately, with no clock edge required; psda=0 and dutyda=8.
